// File: rtl/arbitro_cache_if.sv
// Signal bundle between the two CPU requesters, the shared memoriaCache port
// and the arbiter. Names follow the cache block's own naming.
interface arbitro_cache_if;
    // Handshake: a requester holds reqN with stable fields until the edge that
    // raises gntN. After that edge the fields may change freely. The requester
    // then waits for the one-cycle doneN pulse; rdata is valid while doneN is high.
    logic       req0;
    logic       req1;
    logic       wren0;
    logic       wren1;
    logic [2:0] data0;
    logic [2:0] data1;
    logic [4:0] address0;
    logic [4:0] address1;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [2:0] rdata;
    logic       busy;

    logic       cacheWren;
    logic [2:0] cacheData;
    logic [4:0] cacheAddress;
    logic       hit;
    logic       writeBack;
    logic [2:0] dadoParaCPU;

    logic [7:0] hitCount;
    logic [7:0] missCount;
    logic [2:0] state;

    modport master (
        output req0, req1, wren0, wren1, data0, data1, address0, address1,
        output hit, writeBack, dadoParaCPU,
        input  gnt0, gnt1, done0, done1, rdata, busy,
        input  cacheWren, cacheData, cacheAddress, hitCount, missCount, state
    );

    modport slave (
        input  req0, req1, wren0, wren1, data0, data1, address0, address1,
        input  hit, writeBack, dadoParaCPU,
        output gnt0, gnt1, done0, done1, rdata, busy,
        output cacheWren, cacheData, cacheAddress, hitCount, missCount, state
    );
endinterface

// File: rtl/arbitro_cache.sv
// Round-robin arbiter that sequences one CPU access at a time through the
// single memoriaCache port, with saturating hit/miss statistics.
module arbitro_cache #(
    parameter int ACC_CYCLES  = 2,
    parameter int MISS_CYCLES = 2,
    parameter int WB_CYCLES   = 2
) (
    input  logic           clock,
    input  logic           reset_n,
    arbitro_cache_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACESSO = 3'd1,
        WBACK  = 3'd2,
        FALHA  = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [2:0] ACC_LOAD  = 3'(ACC_CYCLES - 1);
    localparam logic [2:0] MISS_LOAD = 3'(MISS_CYCLES - 1);
    localparam logic [2:0] WB_LOAD   = 3'(WB_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       last_grant_q, last_grant_d;
    logic       owner_q, owner_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic       wren_q, wren_d;
    logic [2:0] data_q, data_d;
    logic [4:0] addr_q, addr_d;
    logic [2:0] rdata_q, rdata_d;
    logic [7:0] hit_cnt_q, hit_cnt_d;
    logic [7:0] miss_cnt_q, miss_cnt_d;
    logic       pick;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // 1 selects CPU1; on a tie the port that did not win last time goes first
    assign pick = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            wren_q       <= 1'b0;
            data_q       <= 3'd0;
            addr_q       <= 5'd0;
            rdata_q      <= 3'd0;
            hit_cnt_q    <= 8'd0;
            miss_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            wren_q       <= wren_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            rdata_q      <= rdata_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        gnt0_d       = gnt0_q;
        gnt1_d       = gnt1_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        wren_d       = wren_q;
        data_d       = data_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;

        case (state_q)
            IDLE: begin
                // The grant stays up through the done cycle and drops here,
                // on the same edge that may hand the cache to the other port.
                gnt0_d = 1'b0;
                gnt1_d = 1'b0;
                if (bus.req0 || bus.req1) begin
                    owner_d = pick;
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                    wren_d  = pick ? bus.wren1    : bus.wren0;
                    data_d  = pick ? bus.data1    : bus.data0;
                    addr_d  = pick ? bus.address1 : bus.address0;
                    cnt_d   = ACC_LOAD;
                    state_d = ACESSO;
                end
            end

            ACESSO: begin
                if (cnt_q == 3'd0) begin
                    if (bus.hit) begin
                        rdata_d   = bus.dadoParaCPU;
                        hit_cnt_d = sat_inc(hit_cnt_q);
                        wren_d    = 1'b0;
                        state_d   = RESP;
                    end else begin
                        miss_cnt_d = sat_inc(miss_cnt_q);
                        if (bus.writeBack) begin
                            cnt_d   = WB_LOAD;
                            state_d = WBACK;
                        end else begin
                            cnt_d   = MISS_LOAD;
                            state_d = FALHA;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            WBACK: begin
                if (cnt_q == 3'd0) begin
                    cnt_d   = MISS_LOAD;
                    state_d = FALHA;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            FALHA: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = bus.dadoParaCPU;
                    wren_d  = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            RESP: begin
                done0_d      = ~owner_q;
                done1_d      = owner_q;
                last_grant_d = owner_q;
                wren_d       = 1'b0;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                wren_d  = 1'b0;
            end
        endcase
    end

    assign bus.gnt0         = gnt0_q;
    assign bus.gnt1         = gnt1_q;
    assign bus.done0        = done0_q;
    assign bus.done1        = done1_q;
    assign bus.rdata        = rdata_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.cacheWren    = wren_q;
    assign bus.cacheData    = data_q;
    assign bus.cacheAddress = addr_q;
    assign bus.hitCount     = hit_cnt_q;
    assign bus.missCount    = miss_cnt_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_arbitro_cache.sv
// Directed bench for arbitro_cache: latency, grant timing, arbitration order,
// reset abandonment and counter saturation against hand-computed values.
module tb_arbitro_cache;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACESSO = 3'd1;
    localparam logic [2:0] S_WBACK  = 3'd2;
    localparam logic [2:0] S_FALHA  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    arbitro_cache_if bus ();

    arbitro_cache #(.ACC_CYCLES(2), .MISS_CYCLES(2), .WB_CYCLES(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] exp_q[$];
    logic [2:0] st_log [0:39];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.req0 = 1'b0;  bus.req1 = 1'b0;
        bus.wren0 = 1'b0; bus.wren1 = 1'b0;
        bus.data0 = 3'd0; bus.data1 = 3'd0;
        bus.address0 = 5'd0; bus.address1 = 5'd0;
        bus.hit = 1'b0; bus.writeBack = 1'b0; bus.dadoParaCPU = 3'd0;
    endtask

    task automatic wait_done(input bit port, output int at);
        bit seen;
        seen = 1'b0;
        at   = -1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clock);
            if (port ? bus.done1 : bus.done0) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        if (!seen) check("done timeout", 32'd0, 32'd1);
    endtask

    // Called at a negedge with the arbiter idle; returns at the negedge after the done cycle.
    task automatic run_txn(input bit port, input bit wr, input logic [2:0] d, input logic [4:0] a,
                           input bit h, input bit wb, input logic [2:0] dado,
                           input int exp_lat, input string tag);
        int c0, gnt_cyc, wr_cyc, bad_bus, lat;
        logic [2:0] exp_rd;
        bit seen;
        bus.hit = h; bus.writeBack = wb; bus.dadoParaCPU = dado;
        if (port) begin
            bus.req1 = 1'b1; bus.wren1 = wr; bus.data1 = d; bus.address1 = a;
        end else begin
            bus.req0 = 1'b1; bus.wren0 = wr; bus.data0 = d; bus.address0 = a;
        end
        exp_q.push_back(dado);
        c0 = cyc; gnt_cyc = 0; wr_cyc = 0; bad_bus = 0; lat = -1; seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clock);
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
            st_log[k] = bus.state;
            if (port ? bus.gnt1 : bus.gnt0) gnt_cyc++;
            if (port ? bus.gnt0 : bus.gnt1) bad_bus++;
            if (bus.cacheWren) wr_cyc++;
            if ((bus.state inside {S_ACESSO, S_WBACK, S_FALHA}) &&
                (bus.cacheAddress !== a || bus.cacheData !== d)) bad_bus++;
            if (port ? bus.done1 : bus.done0) begin
                seen = 1'b1;
                lat  = cyc - (c0 + 1);
            end
        end
        exp_rd = exp_q.pop_front();
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " gnt cycles"}, gnt_cyc, exp_lat + 1);
        check({tag, " cacheWren cycles"}, wr_cyc, wr ? exp_lat - 1 : 0);
        check({tag, " bus/overlap errors"}, bad_bus, 0);
        check({tag, " rdata"}, bus.rdata, exp_rd);
        @(negedge clock);
        check({tag, " done one cycle"}, port ? bus.done1 : bus.done0, 0);
        check({tag, " gnt released"}, port ? bus.gnt1 : bus.gnt0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int at, cg, pulses, first_done, last_done;
        logic [2:0] exp_st [0:7];
        drive_idle();

        @(negedge clock);
        @(negedge clock);
        check("rst state", bus.state, S_IDLE);
        check("rst gnt", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.cacheWren}, 0);
        check("rst cache bus", {bus.cacheData, bus.cacheAddress, bus.rdata}, 0);
        check("rst counters", {bus.hitCount, bus.missCount}, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Clean miss read from CPU0
        run_txn(1'b0, 1'b0, 3'b000, 5'b10000, 1'b0, 1'b0, 3'b011, 5, "clean miss");
        check("missCount after clean miss", bus.missCount, 1);
        check("hitCount after clean miss", bus.hitCount, 0);

        // Write hit from CPU1
        run_txn(1'b1, 1'b1, 3'b101, 5'b00001, 1'b1, 1'b0, 3'b010, 3, "write hit");
        check("hitCount after write hit", bus.hitCount, 1);
        check("cacheAddress kept in idle", bus.cacheAddress, 5'b00001);

        // Tie: CPU0 first, then CPU1 on the idle edge after done0 with both still requesting
        bus.hit = 1'b1; bus.writeBack = 1'b0; bus.dadoParaCPU = 3'b110;
        bus.req0 = 1'b1; bus.wren0 = 1'b1; bus.data0 = 3'b100; bus.address0 = 5'b01001;
        bus.req1 = 1'b1; bus.wren1 = 1'b0; bus.data1 = 3'b000; bus.address1 = 5'b00101;
        @(negedge clock);
        cg = cyc;
        check("tie1 gnt", {bus.gnt0, bus.gnt1}, 2'b10);
        check("tie1 cache bus", {bus.cacheWren, bus.cacheData, bus.cacheAddress}, {1'b1, 3'b100, 5'b01001});
        wait_done(1'b0, at);
        check("tie1 latency", at - cg, 3);
        check("tie1 rdata", bus.rdata, 3'b110);
        @(negedge clock);
        cg = cyc;
        check("tie2 gnt", {bus.gnt0, bus.gnt1}, 2'b01);
        check("tie2 cache bus", {bus.cacheWren, bus.cacheAddress}, {1'b0, 5'b00101});
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.dadoParaCPU = 3'b011;
        wait_done(1'b1, at);
        check("tie2 latency", at - cg, 3);
        check("tie2 rdata", bus.rdata, 3'b011);
        check("hitCount after ties", bus.hitCount, 3);
        @(negedge clock);

        // Dirty miss read of 00101 from CPU0
        run_txn(1'b0, 1'b0, 3'b000, 5'b00101, 1'b0, 1'b1, 3'b101, 7, "dirty miss");
        exp_st = '{S_ACESSO, S_ACESSO, S_WBACK, S_WBACK, S_FALHA, S_FALHA, S_RESP, S_IDLE};
        for (int i = 0; i < 8; i++) check($sformatf("dirty state[%0d]", i), st_log[i], exp_st[i]);
        check("missCount after dirty miss", bus.missCount, 2);

        // Reset pulse during WBACK abandons the transaction
        bus.hit = 1'b0; bus.writeBack = 1'b1; bus.dadoParaCPU = 3'b111;
        bus.req1 = 1'b1; bus.wren1 = 1'b0; bus.address1 = 5'b10101;
        for (int k = 0; k < 10 && bus.state != S_WBACK; k++) begin
            @(negedge clock);
            bus.req1 = 1'b0;
        end
        check("reached WBACK", bus.state, S_WBACK);
        #2 reset_n = 1'b0;
        #1;
        check("mid-rst state", bus.state, S_IDLE);
        check("mid-rst flags", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.cacheWren}, 0);
        check("mid-rst counters", {bus.hitCount, bus.missCount}, 0);
        check("mid-rst cache bus", {bus.cacheData, bus.cacheAddress, bus.rdata}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (bus.done0 || bus.done1 || bus.busy) pulses++;
        end
        check("no activity after abandon", pulses, 0);
        run_txn(1'b0, 1'b0, 3'b010, 5'b11111, 1'b1, 1'b0, 3'b001, 3, "fresh after rst");
        check("hitCount fresh", bus.hitCount, 1);
        check("missCount fresh", bus.missCount, 0);

        // 260 back-to-back hits: saturation at 255
        bus.hit = 1'b1; bus.writeBack = 1'b0; bus.dadoParaCPU = 3'b100;
        bus.req0 = 1'b1; bus.wren0 = 1'b0; bus.address0 = 5'b00011;
        pulses = 0; first_done = 0; last_done = 0;
        for (int k = 0; k < 1200 && pulses < 260; k++) begin
            @(negedge clock);
            if (bus.done0) begin
                pulses++;
                if (pulses == 1) first_done = cyc;
                last_done = cyc;
                if (pulses == 253) check("hitCount at 254", bus.hitCount, 254);
                if (pulses == 260) bus.req0 = 1'b0;
            end
        end
        check("saturation pulses", pulses, 260);
        check("hitCount saturated", bus.hitCount, 255);
        check("missCount unchanged", bus.missCount, 0);
        check("back-to-back spacing", last_done - first_done, 259 * 4);
        @(negedge clock);
        @(negedge clock);
        check("idle after saturation", {bus.busy, bus.gnt0, bus.gnt1}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
